// File: rtl/debounce_pkg.sv
// Shared types and constants for the key debouncer slice.
package debounce_pkg;

  // Per-bit debounce state: settled on the accepted level, or counting a change.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_e;

  // Default acceptance window in clock cycles.
  localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;

  // Legal window bounds; the lower bound keeps the counter at least one bit wide.
  localparam int unsigned MIN_STABLE_CYCLES = 2;
  localparam int unsigned MAX_STABLE_CYCLES = 1 << 24;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: FSM, run counter and registered level/rise/fall.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int unsigned stable_cycles = DEFAULT_STABLE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned       CNT_W    = $clog2(stable_cycles);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(stable_cycles - 1);

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             differs;

  assign differs = (in_i != level_q);

  // State register plus registered counter and outputs; reset discards any pending count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state: leave STABLE on the first differing sample, return on bounce-back or acceptance.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STABLE:  if (differs) state_d = PENDING;
      PENDING: begin
        if (!differs)               state_d = STABLE;
        else if (cnt_q == CNT_LAST) state_d = STABLE;
      end
      default: state_d = STABLE;
    endcase
  end

  // Counter and output update: count differing samples, accept on the stable_cycles-th one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (differs) cnt_d = CNT_W'(1);
      end
      PENDING: begin
        if (differs) begin
          if (cnt_q == CNT_LAST) begin
            level_d = in_i;
            rise_d  = in_i;
            fall_d  = ~in_i;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-bit key debouncer: parameter checks and one debounce_bit per input bit.
module key_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned width         = 1,
  parameter int unsigned stable_cycles = DEFAULT_STABLE_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] in,
  output logic [width-1:0] level,
  output logic [width-1:0] rise,
  output logic [width-1:0] fall
);

  // Reject illegal windows at elaboration.
  if (stable_cycles < MIN_STABLE_CYCLES) begin : g_sc_too_small
    $error("key_debouncer: stable_cycles must be >= 2");
  end
  if (stable_cycles > MAX_STABLE_CYCLES) begin : g_sc_too_large
    $error("key_debouncer: stable_cycles must be <= 2**24");
  end
  if (width < 1) begin : g_width_zero
    $error("key_debouncer: width must be >= 1");
  end

  // One independent debouncer per bit.
  for (genvar g = 0; g < width; g++) begin : g_bit
    debounce_bit #(
      .stable_cycles(stable_cycles)
    ) u_bit (
      .clk_i  (clock),
      .rst_i  (reset),
      .in_i   (in[g]),
      .level_o(level[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer (width=2, stable_cycles=4).
module tb_key_debouncer;

  localparam int unsigned W  = 2;
  localparam int unsigned SC = 4;

  logic         clock;
  logic         reset;
  logic [W-1:0] din;
  logic [W-1:0] level, rise, fall;

  int tests = 0;
  int fails = 0;

  key_debouncer #(
    .width        (W),
    .stable_cycles(SC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in   (din),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a change is accepted once the last SC samples taken since
  // reset or the previous acceptance all disagree with the accepted level.
  bit           hist [W][$];
  logic [W-1:0] m_level = '0;
  logic [W-1:0] m_rise  = '0;
  logic [W-1:0] m_fall  = '0;
  int           m_accepts = 0;

  always @(posedge clock) begin
    m_rise = '0;
    m_fall = '0;
    for (int b = 0; b < int'(W); b++) begin
      if (reset) begin
        hist[b].delete();
        m_level[b] = 1'b0;
      end else begin
        hist[b].push_back(din[b]);
        if (hist[b].size() > int'(SC)) void'(hist[b].pop_front());
        if (hist[b].size() == int'(SC)) begin
          bit all_differ;
          all_differ = 1'b1;
          foreach (hist[b][k]) if (hist[b][k] == m_level[b]) all_differ = 1'b0;
          if (all_differ) begin
            m_level[b] = ~m_level[b];
            if (m_level[b]) m_rise[b] = 1'b1;
            else            m_fall[b] = 1'b1;
            m_accepts++;
            hist[b].delete();
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the sampling edge.
  int dut_pulses = 0;
  always @(negedge clock) begin
    chk("level_vs_model", level, m_level);
    chk("rise_vs_model",  rise,  m_rise);
    chk("fall_vs_model",  fall,  m_fall);
    chk("rise_fall_overlap", rise & fall, '0);
    dut_pulses += $countones(rise) + $countones(fall);
  end

  // Drive one sample at the current negedge and advance to the next negedge.
  task automatic step(input logic r, input logic [W-1:0] v);
    reset = r;
    din   = v;
    @(negedge clock);
  endtask

  int pulses20;

  initial begin
    reset = 1'b1;
    din   = '0;
    @(negedge clock);

    // Reset state
    step(1'b1, 2'b00);
    step(1'b1, 2'b11);
    chk("reset_level", level, 2'b00);
    chk("reset_rise",  rise,  2'b00);
    chk("reset_fall",  fall,  2'b00);

    // Bit 0 held high: accepted on the 4th sampling edge
    repeat (3) step(1'b0, 2'b01);
    chk("rise_pre_level", level, 2'b00);
    step(1'b0, 2'b01);
    chk("rise_4th_level", level, 2'b01);
    chk("rise_4th_pulse", rise,  2'b01);
    chk("rise_4th_fall",  fall,  2'b00);
    step(1'b0, 2'b01);
    chk("rise_one_cycle", rise,  2'b00);

    // Three-sample glitch low is rejected
    repeat (3) step(1'b0, 2'b00);
    chk("glitch_level", level, 2'b01);
    step(1'b0, 2'b01);
    chk("glitch_after_level", level, 2'b01);
    chk("glitch_no_fall", fall, 2'b00);

    // Held low: falls on 4th edge, then quiet for 20 cycles
    repeat (3) step(1'b0, 2'b00);
    chk("fall_pre_level", level, 2'b01);
    step(1'b0, 2'b00);
    chk("fall_4th_level", level, 2'b00);
    chk("fall_4th_pulse", fall,  2'b01);
    pulses20 = 0;
    repeat (20) begin
      step(1'b0, 2'b00);
      pulses20 += $countones(rise) + $countones(fall);
    end
    chk("no_repeat_pulse", pulses20, 0);

    // Staggered rises: bit0 from cycle 0, bit1 from cycle 2
    step(1'b0, 2'b01);
    step(1'b0, 2'b01);
    step(1'b0, 2'b11);
    step(1'b0, 2'b11);
    chk("stagger_rise0", rise,  2'b01);
    chk("stagger_lvl0",  level, 2'b01);
    step(1'b0, 2'b11);
    chk("stagger_gap", rise, 2'b00);
    step(1'b0, 2'b11);
    chk("stagger_rise1", rise,  2'b10);
    chk("stagger_lvl1",  level, 2'b11);

    // Reset mid-pending discards the count; fresh window after release
    step(1'b1, 2'b00);
    repeat (3) step(1'b0, 2'b01);
    step(1'b1, 2'b01);
    chk("midreset_level", level, 2'b00);
    chk("midreset_rise",  rise,  2'b00);
    repeat (3) step(1'b0, 2'b01);
    chk("postreset_pre", level, 2'b00);
    step(1'b0, 2'b01);
    chk("postreset_rise",  rise,  2'b01);
    chk("postreset_level", level, 2'b01);

    // Random bounce bursts interleaved with stable runs
    for (int s = 0; s < 400; s++) begin
      logic [W-1:0] v;
      int unsigned  len;
      logic         r;
      v   = W'($urandom_range(3, 0));
      len = $urandom_range(8, 1);
      r   = ($urandom_range(39, 0) == 0);
      for (int unsigned k = 0; k < len; k++) step(r && (k == 0), v);
    end
    step(1'b0, din);

    chk("pulse_count", dut_pulses, m_accepts);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
